// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the issue, writeback-source and register-file write signals
// handled by regfile_wb_scheduler.
//   iss_*  : issuing instruction (valid, rs1, rs2, rd, long) and its stall
//   alu_*  : single-cycle ALU result (valid, rd, data), never back-pressured
//   lsu_*  : LSU result with ready/valid handshake
//   wb_*   : registered register-file write port (en, rd, data)
// master drives the sources and the issue request; slave is the scheduler.
interface regfile_wb_scheduler_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 iss_valid;
  logic [4:0]           iss_rs1;
  logic [4:0]           iss_rs2;
  logic [4:0]           iss_rd;
  logic                 iss_long;
  logic                 iss_stall;

  logic                 alu_valid;
  logic [4:0]           alu_rd;
  logic [WORD_SIZE-1:0] alu_data;

  logic                 lsu_valid;
  logic [4:0]           lsu_rd;
  logic [WORD_SIZE-1:0] lsu_data;
  logic                 lsu_ready;

  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic [WORD_SIZE-1:0] wb_data;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    input  iss_stall,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  wb_en, wb_rd, wb_data
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    output iss_stall,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between the ALU result path
// (no back-pressure, parked in a one-entry hold buffer when it loses) and the
// LSU (ready/valid). Tracks destinations of in-flight long-latency ops in a
// busy scoreboard and stalls issue on RAW/WAW hazards.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : regfile_wb_scheduler_if.slave (issue, ALU, LSU and wb_* signals)
module regfile_wb_scheduler #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_wb_scheduler_if.slave     bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_HOLD,
    SRC_LSU,
    SRC_ALU
  } src_e;

  logic [31:0]          busy;
  logic [31:0]          busy_next;
  logic                 hold_valid;
  logic [4:0]           hold_rd;
  logic [WORD_SIZE-1:0] hold_data;
  logic [3:0]           starve_cnt;

  logic                 wb_en_q;
  logic [4:0]           wb_rd_q;
  logic [WORD_SIZE-1:0] wb_data_q;
  logic                 wb_src_lsu;

  logic                 starve_hit;
  logic                 lsu_ready;
  logic                 lsu_fire;
  logic                 alu_to_hold;
  logic                 iss_stall;
  logic                 issue_set;
  src_e                 src;
  logic [4:0]           win_rd;
  logic [WORD_SIZE-1:0] win_data;

  // A starved LSU only preempts while it is actually presenting a result.
  assign starve_hit = (starve_cnt == LIMIT) && bus.lsu_valid;

  // The LSU is accepted when nothing held is draining and either it is
  // starved or the ALU is idle this cycle.
  assign lsu_ready = !hold_valid && (starve_hit || !bus.alu_valid);
  assign lsu_fire  = bus.lsu_valid && lsu_ready;

  // An ALU result that loses the port (to the hold buffer draining, or to a
  // starved LSU) is parked; lsu_fire with alu_valid only happens when starved.
  assign alu_to_hold = bus.alu_valid && (hold_valid || lsu_fire);

  always_comb begin
    src      = SRC_NONE;
    win_rd   = '0;
    win_data = '0;
    if (hold_valid) begin
      src      = SRC_HOLD;
      win_rd   = hold_rd;
      win_data = hold_data;
    end else if (lsu_fire) begin
      src      = SRC_LSU;
      win_rd   = bus.lsu_rd;
      win_data = bus.lsu_data;
    end else if (bus.alu_valid) begin
      src      = SRC_ALU;
      win_rd   = bus.alu_rd;
      win_data = bus.alu_data;
    end
  end

  assign iss_stall = bus.iss_valid &&
                     (busy[bus.iss_rs1] || busy[bus.iss_rs2] || busy[bus.iss_rd] ||
                      hold_valid || starve_hit);

  assign issue_set = bus.iss_valid && !iss_stall && bus.iss_long && (bus.iss_rd != 5'd0);

  // Clear is applied before set; the WAW stall guarantees they never target
  // the same register in one cycle.
  always_comb begin
    busy_next = busy;
    if (wb_en_q && wb_src_lsu) begin
      busy_next[wb_rd_q] = 1'b0;
    end
    if (issue_set) begin
      busy_next[bus.iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      starve_cnt <= '0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_src_lsu <= 1'b0;
    end else begin
      busy <= busy_next;

      // A winner aimed at x0 still consumes the slot but never writes.
      wb_en_q    <= (src != SRC_NONE) && (win_rd != 5'd0);
      wb_src_lsu <= (src == SRC_LSU);
      if (src != SRC_NONE) begin
        wb_rd_q   <= win_rd;
        wb_data_q <= win_data;
      end

      hold_valid <= alu_to_hold;
      if (alu_to_hold) begin
        hold_rd   <= bus.alu_rd;
        hold_data <= bus.alu_data;
      end

      if (!bus.lsu_valid || lsu_fire) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign bus.iss_stall = iss_stall;
  assign bus.lsu_ready = lsu_ready;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler (WORD_SIZE=32, STARVE_LIMIT=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the inputs settle, well away from the next rising edge.
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_wb_scheduler_if #(.WORD_SIZE(32)) bus ();

  regfile_wb_scheduler #(
    .WORD_SIZE   (32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.iss_rd    = '0;
    bus.iss_long  = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic lng);
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
    bus.iss_rd    = rd;
    bus.iss_long  = lng;
  endtask

  task automatic test_reset();
    step();
    idle();
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL reset_setup_issue: iss_stall=%0b want 0", bus.iss_stall);
    end
    step();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h0000_0011;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h5555_0006;
    repeat (4) step();
    // hold_valid=1 and busy[5]=1 here; LSU rd=6 is on wb
    bus.alu_valid = 1'b0;
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL reset_pre_stall: iss_stall=%0b want 1", bus.iss_stall);
    end
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd6) begin
      bad++; $display("FAIL reset_pre_wb: wb_en=%0b wb_rd=%0d want 1/6", bus.wb_en, bus.wb_rd);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.wb_en !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
      bad++; $display("FAIL reset_wb: en=%0b rd=%0d data=%h want 0/0/0", bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: iss_stall=%0b want 0", bus.iss_stall);
    end
    total++;
    if (bus.lsu_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: lsu_ready=%0b want 1", bus.lsu_ready);
    end
    idle();
    #3;
    rst = 1'b1;
    step();
    issue(5'd5, 5'd5, 5'd5, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0 || bus.wb_en !== 1'b0 || bus.lsu_ready !== 1'b1) begin
      bad++; $display("FAIL reset_after: stall=%0b wb_en=%0b ready=%0b want 0/0/1",
                      bus.iss_stall, bus.wb_en, bus.lsu_ready);
    end
  endtask

  task automatic test_lsu_only();
    step();
    idle();
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    step();
    issue(5'd7, 5'd0, 5'd0, 1'b0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (bus.lsu_ready !== 1'b1) begin
      bad++; $display("FAIL lsu_ready: lsu_ready=%0b want 1", bus.lsu_ready);
    end
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL lsu_busy_raw: iss_stall=%0b want 1", bus.iss_stall);
    end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL lsu_wb: en=%0b rd=%0d data=%h want 1/7/deadbeef", bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL lsu_busy_until_commit: iss_stall=%0b want 1", bus.iss_stall);
    end
    step();
    #1;
    total++;
    if (bus.iss_stall !== 1'b0 || bus.wb_en !== 1'b0) begin
      bad++; $display("FAIL lsu_busy_cleared: stall=%0b wb_en=%0b want 0/0", bus.iss_stall, bus.wb_en);
    end
  endtask

  task automatic test_starvation();
    bit          ready_tab [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 1};
    bit          stall_tab [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    bit          en_tab    [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  rd_tab    [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5, 5'd6, 5'd0};
    logic [31:0] exp_data;
    step();
    idle();
    for (int k = 0; k < 9; k++) begin
      issue(5'd0, 5'd0, 5'd0, 1'b0);
      bus.alu_valid = (k < 6);
      bus.alu_rd    = (k < 6) ? 5'(k + 1) : 5'd0;
      bus.alu_data  = 32'h100 + 32'(k + 1);
      bus.lsu_valid = (k < 4);
      bus.lsu_rd    = 5'd9;
      bus.lsu_data  = 32'hA5A5_0009;
      #1;
      total++;
      if (bus.lsu_ready !== ready_tab[k]) begin
        bad++; $display("FAIL starve_ready[%0d]: lsu_ready=%0b want %0b", k, bus.lsu_ready, ready_tab[k]);
      end
      total++;
      if (bus.iss_stall !== stall_tab[k]) begin
        bad++; $display("FAIL starve_stall[%0d]: iss_stall=%0b want %0b", k, bus.iss_stall, stall_tab[k]);
      end
      if (k > 0) begin
        exp_data = (rd_tab[k] == 5'd9) ? 32'hA5A5_0009 : 32'h100 + 32'(rd_tab[k]);
        total++;
        if (bus.wb_en !== en_tab[k] ||
            (en_tab[k] && (bus.wb_rd !== rd_tab[k] || bus.wb_data !== exp_data))) begin
          bad++; $display("FAIL starve_wb[%0d]: en=%0b rd=%0d data=%h want %0b/%0d/%h",
                          k, bus.wb_en, bus.wb_rd, bus.wb_data, en_tab[k], rd_tab[k], exp_data);
        end
      end
      step();
    end
  endtask

  task automatic test_hazard();
    idle();
    issue(5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL hazard_issue_long: iss_stall=%0b want 0", bus.iss_stall);
    end
    step();
    issue(5'd0, 5'd3, 5'd10, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL hazard_raw: iss_stall=%0b want 1", bus.iss_stall);
    end
    step();
    issue(5'd0, 5'd0, 5'd3, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL hazard_waw: iss_stall=%0b want 1", bus.iss_stall);
    end
    issue(5'd0, 5'd3, 5'd10, 1'b0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h0000_0033;
    #1;
    total++;
    if (bus.lsu_ready !== 1'b1 || bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL hazard_lsu_accept: ready=%0b stall=%0b want 1/1", bus.lsu_ready, bus.iss_stall);
    end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd3 || bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL hazard_wb_stage: en=%0b rd=%0d stall=%0b want 1/3/1", bus.wb_en, bus.wb_rd, bus.iss_stall);
    end
    step();
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL hazard_raw_release: iss_stall=%0b want 0", bus.iss_stall);
    end
    issue(5'd0, 5'd0, 5'd3, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL hazard_waw_release: iss_stall=%0b want 0", bus.iss_stall);
    end
  endtask

  task automatic test_x0();
    step();
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL x0_issue: iss_stall=%0b want 0", bus.iss_stall);
    end
    step();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h0000_0022;
    step();
    bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_00FF;
    #1;
    total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd2 || bus.wb_data !== 32'h22) begin
      bad++; $display("FAIL x0_alu_prev: en=%0b rd=%0d data=%h want 1/2/22", bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    step();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0000_00EE;
    #1;
    total++;
    if (bus.wb_en !== 1'b0) begin
      bad++; $display("FAIL x0_alu_wb: wb_en=%0b want 0", bus.wb_en);
    end
    total++;
    if (bus.lsu_ready !== 1'b1) begin
      bad++; $display("FAIL x0_lsu_ready: lsu_ready=%0b want 1", bus.lsu_ready);
    end
    step();
    bus.lsu_valid = 1'b0;
    #1;
    total++;
    if (bus.wb_en !== 1'b0) begin
      bad++; $display("FAIL x0_lsu_wb: wb_en=%0b want 0", bus.wb_en);
    end
  endtask

  task automatic test_back_to_back();
    step();
    idle();
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    step();
    bus.iss_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h0000_0044;
    step();
    bus.lsu_valid = 1'b0;
    issue(5'd0, 5'd0, 5'd8, 1'b1);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0 || bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd4) begin
      bad++; $display("FAIL b2b_same_cycle: stall=%0b en=%0b rd=%0d want 0/1/4", bus.iss_stall, bus.wb_en, bus.wb_rd);
    end
    step();
    issue(5'd4, 5'd0, 5'd0, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL b2b_clear4: iss_stall=%0b want 0", bus.iss_stall);
    end
    issue(5'd8, 5'd0, 5'd0, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b1) begin
      bad++; $display("FAIL b2b_set8: iss_stall=%0b want 1", bus.iss_stall);
    end
    bus.iss_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd8; bus.lsu_data = 32'h0000_0088;
    step();
    bus.lsu_valid = 1'b0;
    step();
    issue(5'd0, 5'd0, 5'd8, 1'b0);
    #1;
    total++;
    if (bus.iss_stall !== 1'b0) begin
      bad++; $display("FAIL b2b_clear8: iss_stall=%0b want 0", bus.iss_stall);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_lsu_only();
    test_starvation();
    test_hazard();
    test_x0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single register-file write port between two writeback sources:
  - the single-cycle ALU result path, which cannot be back-pressured;
  - the long-latency load/store unit (LSU), which has a ready/valid handshake.
- Keeps a busy scoreboard for destinations of long-latency ops and raises an issue stall on RAW/WAW hazards.
- Its registered wb_* outputs drive the register file's en/rd/data inputs directly.

Parameters:
- WORD_SIZE, 32, width of data paths.
- STARVE_LIMIT, 3, consecutive cycles an LSU request may be refused before it preempts the ALU (range 1..15).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- iss_valid  input  1  an instruction is attempting issue this cycle
- iss_rs1  input  5  source register 1 of issuing instruction
- iss_rs2  input  5  source register 2 of issuing instruction
- iss_rd  input  5  destination of issuing instruction
- iss_long  input  1  issuing instruction writes back via LSU
- iss_stall  output  1  combinational; issue must hold this cycle
- alu_valid  input  1  ALU result present; always accepted
- alu_rd  input  5  ALU destination
- alu_data  input  WORD_SIZE  ALU result
- lsu_valid  input  1  LSU result present
- lsu_rd  input  5  LSU destination
- lsu_data  input  WORD_SIZE  LSU result
- lsu_ready  output  1  combinational; LSU result accepted when lsu_valid && lsu_ready
- wb_en  output  1  registered register-file write enable
- wb_rd  output  5  registered write address
- wb_data  output  WORD_SIZE  registered write data

Behaviour:
- Reset: rst low asynchronously clears the following, mid-operation included; any pending LSU grant or held result is discarded.
  - wb_en=0, wb_rd=0, wb_data=0.
  - busy[31:0]=0, hold_valid=0, starve_cnt=0.
- State:
  - 32-bit busy scoreboard (bit 0 hardwired 0).
  - 1-entry ALU hold buffer (hold_valid, hold_rd, hold_data).
  - starve_cnt.
  - wb_src_lsu flag registered alongside wb_*.
- Port selection each cycle, first match wins:
  1. hold_valid: write hold. A concurrent alu_valid loads into hold; otherwise hold clears. lsu_ready=0.
  2. starve_cnt==STARVE_LIMIT && lsu_valid: LSU wins. A concurrent alu_valid loads into hold. lsu_ready=1.
  3. alu_valid: ALU wins. lsu_ready=0.
  4. Otherwise lsu_ready=1; LSU wins if lsu_valid.
- No ALU result is ever dropped.
- Write latency: the winner appears on wb_* at the next clk edge; the register file commits on the edge after that.
- Destination x0: a winner with rd==0 still consumes its slot (LSU handshake completes, hold drains). wb_en is 0 that cycle.
- starve_cnt:
  - increments when lsu_valid && !lsu_ready, saturating at STARVE_LIMIT;
  - clears on LSU handshake or when lsu_valid==0.
- Scoreboard set: on iss_valid && !iss_stall && iss_long && iss_rd!=0, busy[iss_rd] sets at the next edge.
- Scoreboard clear: when wb_en && wb_src_lsu, busy[wb_rd] clears at the same edge the register file commits. Set and clear on different registers in the same cycle both take effect.
- iss_stall=1 when iss_valid and any of the following holds:
  - busy[iss_rs1] (rs1!=0);
  - busy[iss_rs2] (rs2!=0);
  - busy[iss_rd] (rd!=0);
  - hold_valid;
  - starve_cnt==STARVE_LIMIT && lsu_valid.
- iss_stall=0 whenever iss_valid=0.
- Set/clear on the same register in the same cycle cannot occur: the WAW stall prevents it.
- An LSU result whose rd is not busy is still written; the scoreboard is unaffected.

Test Plan:
- Reset mid-stream: busy[5]=1, hold_valid=1, then rst=0 → all wb_* 0, iss_stall=0, lsu_ready=1 immediately; all state 0 after release.
- LSU only:
  - lsu_valid=1, lsu_rd=7, lsu_data=0xDEADBEEF, alu idle → lsu_ready=1;
  - next cycle wb_en=1, wb_rd=7, wb_data=0xDEADBEEF;
  - busy[7] cleared one edge later.
- Starvation (STARVE_LIMIT=3):
  - alu_valid=1 every cycle, rd=1..6, with lsu_valid=1, rd=9 → lsu_ready=0 for 3 cycles, then 1 on cycle 4; wb shows LSU rd=9.
  - The concurrent ALU result enters hold and appears next cycle; iss_stall=1 while hold_valid; ALU results stay in order.
- Hazard:
  - issue long rd=3 → busy[3]=1;
  - next issue rs2=3 → iss_stall=1 until the LSU write to 3 commits, then 0;
  - issue with rd=3 also stalls (WAW).
- x0 handling:
  - issue long rd=0 → busy unchanged;
  - ALU result rd=0 → wb_en=0;
  - LSU result rd=0 → handshake completes, wb_en=0.
- Simultaneous: an LSU write to rd=4 clears busy[4] in the same cycle an issue with long rd=8 sets busy[8] → both take effect.
